i2c_target: RTL and testbench

I2C target (responder) exposing the board's 256-byte register space to an external I2C controller, such as a ground-support tester or companion processor. It is the counterpart of the I2C_Driver controller blocks. It decodes START/STOP, matches a 7-bit device address, drives ACK and read data on an open-drain SDA, and presents a byte-addressed read/write port to the register file. It sits beside Sensor_Reg and shares its addr/data style.

---
 rtl/i2c_target.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target (responder) exposing a 256-byte register space.
// Decodes START/STOP, matches a 7-bit device address, ACKs and drives read
// data on open-drain SDA, and offers a byte-addressed read/write port.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   scl       I2C clock (never stretched)
//   sda       I2C data, open-drain (driven 1'b0 or released)
//   reg_addr  current register pointer
//   reg_data  read data for reg_addr, valid 1 clk after reg_addr changes
//   wr_en     one-clk write strobe
//   wr_data   write byte, valid while wr_en is high
//   busy      high from an address-matched START until STOP
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
    } state_e;

    // Synchronizers reset to the idle-bus level so reset release is not an edge.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_p, sda_p;
    logic scl_s, sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Registered bus events; sda_bit_q is the SDA level aligned with them.
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_p      <= 1'b1;
            sda_p      <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_p      <= scl_s;
            sda_p      <= sda_s;
            scl_rise_q <= scl_s & ~scl_p;
            scl_fall_q <= ~scl_s & scl_p;
            start_q    <= scl_s & scl_p & sda_p & ~sda_s;
            stop_q     <= scl_s & scl_p & ~sda_p & sda_s;
            sda_bit_q  <= sda_s;
        end
    end

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       sda_oe_q, sda_oe_d;
    logic       phase_q, phase_d;   // ACK slot: 0 = waiting for first fall, 1 = driving
    logic       rw_q, rw_d;
    logic       first_q, first_d;   // next write byte is the pointer
    logic       acked_q, acked_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;
    logic [7:0] byte_in;

    assign byte_in = {shreg_q[6:0], sda_bit_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            acked_q    <= 1'b0;
            reg_addr_q <= 8'h00;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sda_oe_q   <= sda_oe_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            acked_q    <= acked_d;
            reg_addr_q <= reg_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sda_oe_d   = sda_oe_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        first_d    = first_q;
        acked_d    = acked_q;
        reg_addr_d = reg_addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;

        // Post-write pointer increment lands the clk after the strobe.
        if (wr_en_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (stop_q) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_q) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: begin
                end
                StAddr: begin
                    if (scl_rise_q) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            rw_d      = sda_bit_q;
                            phase_d   = 1'b0;
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = StAddrAck;
                                busy_d  = 1'b1;
                                first_d = 1'b1;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddrAck, StWrAck: begin
                    if (scl_fall_q) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == StAddrAck && rw_q) begin
                                shreg_d  = reg_data;
                                sda_oe_d = ~reg_data[7];
                                state_d  = StRdByte;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = StWrByte;
                            end
                        end
                    end
                end
                StWrByte: begin
                    if (scl_rise_q) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            state_d   = StWrAck;
                            if (first_q) begin
                                reg_addr_d = byte_in;
                                first_d    = 1'b0;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_data_d = byte_in;
                            end
                        end
                    end
                end
                StRdByte: begin
                    if (scl_rise_q) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q) begin
                        if (bit_cnt_q == 4'd8) begin
                            // Release SDA so the controller can ACK/NACK.
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            acked_d   = 1'b0;
                            state_d   = StRdAck;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise_q) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        acked_d    = ~sda_bit_q;
                        if (sda_bit_q) begin
                            state_d = StIgnore;
                        end
                    end else if (scl_fall_q && acked_q) begin
                        shreg_d   = reg_data;
                        sda_oe_d  = ~reg_data[7];
                        bit_cnt_d = 4'd0;
                        state_d   = StRdByte;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Gating with rst_n releases the line combinationally on reset assertion.
    assign sda      = (sda_oe_q && rst_n) ? 1'b0 : 1'bz;
    assign reg_addr = reg_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 200;  // quarter SCL period (10 clk)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, reg_data, wr_data;
    logic       wr_en, busy;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    // Register file model
    logic [7:0] mem [256];
    logic       mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h7C;
            mem_init <= 1'b1;
        end else if (wr_en) begin
            mem[reg_addr] <= wr_data;
        end
        reg_data <= mem[reg_addr];
    end

    int passed = 0;
    int fails = 0;
    int total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    wr_t        wr_e;

    // Write scoreboard: every wr_en sample must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (wr_q.size() == 0) begin
                check("wr_en_unexpected", {31'b0, wr_en}, 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", {24'b0, reg_addr}, {24'b0, wr_e.addr});
                check("wr_data", {24'b0, wr_data}, {24'b0, wr_e.data});
            end
        end
    end

    // Counts clocks on which someone other than the controller pulls SDA low.
    int low_cnt = 0;
    always @(negedge clk) begin
        if (!sda_low && sda === 1'b0) low_cnt <= low_cnt + 1;
    end

    task automatic start_c();
        sda_low = 1'b0; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b1; #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic stop_c();
        sda_low = 1'b1; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b0; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b; #Q;
        scl = 1'b1;   #(2*Q);
        scl = 1'b0;   #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_low = 1'b0; #Q;
        scl = 1'b1;     #Q;
        ack = (sda === 1'b0); #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl = 1'b1;
            #Q; b[i] = (sda !== 1'b0);
            #Q; scl = 1'b0;
            #Q;
        end
        send_bit(~ack);
    endtask

    logic       ack;
    logic [7:0] rb;
    int         lc0;

    initial begin
        #103;
        check("rst_sda",      {31'b0, sda},      32'd1);
        check("rst_reg_addr", {24'b0, reg_addr}, 32'h00);
        check("rst_wr_en",    {31'b0, wr_en},    32'd0);
        check("rst_wr_data",  {24'b0, wr_data},  32'h00);
        check("rst_busy",     {31'b0, busy},     32'd0);
        rst_n = 1'b1;
        #(4*Q);

        // Pointer + two writes
        wr_q.push_back('{addr: 8'h10, data: 8'hAA});
        wr_q.push_back('{addr: 8'h11, data: 8'h55});
        start_c();
        write_byte(8'h84, ack); check("t1_addr_ack", {31'b0, ack}, 32'd1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        write_byte(8'h10, ack); check("t1_ptr_ack", {31'b0, ack}, 32'd1);
        write_byte(8'hAA, ack); check("t1_d0_ack", {31'b0, ack}, 32'd1);
        write_byte(8'h55, ack); check("t1_d1_ack", {31'b0, ack}, 32'd1);
        stop_c(); #Q;
        check("t1_reg_addr", {24'b0, reg_addr}, 32'h12);
        check("t1_busy_off", {31'b0, busy}, 32'd0);
        check("t1_wr_left", wr_q.size(), 32'd0);

        // Pointer set, repeated START, read two bytes
        start_c();
        write_byte(8'h84, ack); check("t2_addr_ack", {31'b0, ack}, 32'd1);
        write_byte(8'h20, ack); check("t2_ptr_ack", {31'b0, ack}, 32'd1);
        start_c();
        rd_q.push_back(mem[8'h20]);
        rd_q.push_back(mem[8'h21]);
        write_byte(8'h85, ack); check("t2_raddr_ack", {31'b0, ack}, 32'd1);
        read_byte(1'b1, rb); check("t2_rd0", {24'b0, rb}, {24'b0, rd_q.pop_front()});
        read_byte(1'b0, rb); check("t2_rd1", {24'b0, rb}, {24'b0, rd_q.pop_front()});
        stop_c(); #Q;
        check("t2_reg_addr", {24'b0, reg_addr}, 32'h22);

        // Address mismatch
        lc0 = low_cnt;
        start_c();
        write_byte(8'h90, ack); check("t3_addr_nack", {31'b0, ack}, 32'd0);
        check("t3_busy", {31'b0, busy}, 32'd0);
        write_byte(8'h01, ack); check("t3_data_nack", {31'b0, ack}, 32'd0);
        stop_c(); #Q;
        check("t3_sda_driven", low_cnt, lc0);
        check("t3_busy_end", {31'b0, busy}, 32'd0);

        // Pointer wrap
        wr_q.push_back('{addr: 8'hFF, data: 8'h01});
        wr_q.push_back('{addr: 8'h00, data: 8'h02});
        start_c();
        write_byte(8'h84, ack); check("t4_addr_ack", {31'b0, ack}, 32'd1);
        write_byte(8'hFF, ack); check("t4_ptr_ack", {31'b0, ack}, 32'd1);
        write_byte(8'h01, ack); check("t4_d0_ack", {31'b0, ack}, 32'd1);
        write_byte(8'h02, ack); check("t4_d1_ack", {31'b0, ack}, 32'd1);
        stop_c(); #Q;
        check("t4_reg_addr", {24'b0, reg_addr}, 32'h01);
        check("t4_wr_left", wr_q.size(), 32'd0);

        // Reset while the target drives a 0 bit (mem[0x40] = 0x3C)
        start_c();
        write_byte(8'h84, ack);
        write_byte(8'h40, ack);
        start_c();
        write_byte(8'h85, ack); check("t5_raddr_ack", {31'b0, ack}, 32'd1);
        sda_low = 1'b0; #Q;
        scl = 1'b1;     #Q;
        check("t5_drive0", {31'b0, sda}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t5_sda_rel",  {31'b0, sda},      32'd1);
        check("t5_reg_addr", {24'b0, reg_addr}, 32'h00);
        check("t5_wr_en",    {31'b0, wr_en},    32'd0);
        check("t5_wr_data",  {24'b0, wr_data},  32'h00);
        check("t5_busy",     {31'b0, busy},     32'd0);
        #Q;
        rst_n = 1'b1;
        #(2*Q);
        rd_q.push_back(mem[8'h00]);
        start_c();
        write_byte(8'h85, ack); check("t5_addr_ack", {31'b0, ack}, 32'd1);
        read_byte(1'b0, rb); check("t5_rd", {24'b0, rb}, {24'b0, rd_q.pop_front()});
        stop_c(); #Q;
        check("t5_reg_addr_end", {24'b0, reg_addr}, 32'h01);

        // Aborted write
        start_c();
        write_byte(8'h84, ack); check("t6_addr_ack", {31'b0, ack}, 32'd1);
        write_byte(8'h30, ack); check("t6_ptr_ack", {31'b0, ack}, 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        stop_c(); #Q;
        check("t6_reg_addr", {24'b0, reg_addr}, 32'h30);
        check("t6_busy", {31'b0, busy}, 32'd0);
        #(4*Q);
        check("end_wr_left", wr_q.size(), 32'd0);
        check("end_rd_left", rd_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
